// File: rtl/attn_score_buffer.sv
// Ping-pong score buffer between the attention spike accumulator and the
// softmax/readout consumer. Two banks alternate: one fills while the other
// is drained; tiles are presented to the reader in completion order.

// One bank: word storage plus its EMPTY/FILLING/FULL state.
module attn_score_bank #(
  parameter int DATA_W     = 20,
  parameter int ADDR_W     = 8,
  parameter int TILE_WORDS = 256
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              wr_en,
  input  logic              wr_last,
  input  logic              rel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_q,
  output logic [1:0]        st
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [DATA_W-1:0] mem [TILE_WORDS];

  // Storage is never cleared; bank state alone decides what is valid.
  always_ff @(posedge s_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read is a plain array lookup; the top registers the selected bank.
  assign rd_q = mem[rd_addr];

  // Release and write never target the same bank in one cycle (a released
  // bank is FULL, a written bank is not), so ordering here is arbitrary.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst)        st <= ST_EMPTY;
    else if (rel)     st <= ST_EMPTY;
    else if (wr_en)   st <= wr_last ? ST_FULL : ST_FILL;
  end
endmodule

// Top: write/read pointers, tile bookkeeping and registered read port.
module attn_score_buffer #(
  parameter  int TIME_STEPS = 4,
  parameter  int CNT_W      = 5,
  parameter  int TILE_WORDS = 256,
  localparam int DATA_W     = CNT_W * TIME_STEPS,
  localparam int ADDR_W     = $clog2(TILE_WORDS)
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic [DATA_W-1:0] i_Calc_data,
  input  logic              i_Calc_valid,
  output logic              o_AttnRAM_Ready,
  output logic              o_rd_valid,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_rd_done,
  output logic [7:0]        o_tile_cnt,
  output logic              o_ovf
);
  localparam logic [1:0] ST_FULL = 2'd2;

  logic [1:0][1:0]        bank_st;
  logic [1:0][DATA_W-1:0] bank_q;
  logic                   wr_sel, rd_sel;
  logic [ADDR_W-1:0]      wr_addr;
  logic                   wr_ok, wr_last, rel;

  assign o_AttnRAM_Ready = (bank_st[wr_sel] != ST_FULL);
  assign o_rd_valid      = (bank_st[rd_sel] == ST_FULL);
  assign wr_ok   = i_Calc_valid && o_AttnRAM_Ready;
  assign wr_last = wr_ok && (wr_addr == ADDR_W'(TILE_WORDS - 1));
  assign rel     = i_rd_done && o_rd_valid;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    attn_score_bank #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TILE_WORDS(TILE_WORDS)
    ) u_bank (
      .s_clk   (s_clk),
      .s_rst   (s_rst),
      .wr_en   (wr_ok   && (wr_sel == 1'(b))),
      .wr_last (wr_last && (wr_sel == 1'(b))),
      .rel     (rel     && (rd_sel == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (i_Calc_data),
      .rd_addr (i_rd_addr),
      .rd_q    (bank_q[b]),
      .st      (bank_st[b])
    );
  end

  // Write side: advance address, flip banks and count tiles on the last word.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      wr_sel     <= 1'b0;
      wr_addr    <= '0;
      o_tile_cnt <= '0;
    end else if (wr_last) begin
      wr_sel     <= ~wr_sel;
      wr_addr    <= '0;
      o_tile_cnt <= o_tile_cnt + 8'd1;
    end else if (wr_ok) begin
      wr_addr    <= wr_addr + ADDR_W'(1);
    end
  end

  // Sticky overflow: a word arrived while the write bank was still FULL.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst)                              o_ovf <= 1'b0;
    else if (i_Calc_valid && !o_AttnRAM_Ready) o_ovf <= 1'b1;
  end

  // Read side: release the head tile and move to the next bank.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst)    rd_sel <= 1'b0;
    else if (rel) rd_sel <= ~rd_sel;
  end

  // Registered read port; reads are honoured even with no valid tile.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst)        o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= bank_q[rd_sel];
  end
endmodule

// File: tb/tb_attn_score_buffer.sv
// Self-checking bench for attn_score_buffer. The reference model tracks
// tiles as a FIFO of completed tiles (sequence numbers head..tail) plus the
// word count of the tile being filled.
module tb_attn_score_buffer;
  localparam int TIME_STEPS = 4;
  localparam int CNT_W      = 5;
  localparam int TILE_WORDS = 256;
  localparam int DATA_W     = CNT_W * TIME_STEPS;
  localparam int ADDR_W     = $clog2(TILE_WORDS);

  logic              s_clk = 1'b0;
  logic              s_rst = 1'b0;
  logic [DATA_W-1:0] i_Calc_data = '0;
  logic              i_Calc_valid = 1'b0;
  logic              o_AttnRAM_Ready, o_rd_valid, o_ovf;
  logic              i_rd_en = 1'b0;
  logic [ADDR_W-1:0] i_rd_addr = '0;
  logic [DATA_W-1:0] o_rd_data;
  logic              i_rd_done = 1'b0;
  logic [7:0]        o_tile_cnt;

  attn_score_buffer #(
    .TIME_STEPS(TIME_STEPS), .CNT_W(CNT_W), .TILE_WORDS(TILE_WORDS)
  ) dut (
    .s_clk(s_clk), .s_rst(s_rst),
    .i_Calc_data(i_Calc_data), .i_Calc_valid(i_Calc_valid),
    .o_AttnRAM_Ready(o_AttnRAM_Ready), .o_rd_valid(o_rd_valid),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .i_rd_done(i_rd_done), .o_tile_cnt(o_tile_cnt), .o_ovf(o_ovf)
  );

  always #5 s_clk = ~s_clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model
  logic [DATA_W-1:0] mm [4][TILE_WORDS];
  int                m_head, m_tail, m_wcnt, m_tcnt;
  logic              m_ovf;
  logic [DATA_W-1:0] m_rd;
  logic              m_rd_known;
  logic              last_re;

  function automatic void model_reset();
    m_head = 0; m_tail = 0; m_wcnt = 0; m_tcnt = 0;
    m_ovf = 1'b0; m_rd = '0; m_rd_known = 1'b1;
  endfunction

  // One clock: drive inputs, update model from pre-edge state, sample at +1.
  task automatic step(input logic v, input logic [DATA_W-1:0] d,
                      input logic re, input int a, input logic dn);
    int nfull;
    i_Calc_valid = v; i_Calc_data = d;
    i_rd_en = re; i_rd_addr = ADDR_W'(a); i_rd_done = dn;
    nfull = m_tail - m_head;
    last_re = re;
    if (re) begin
      if (nfull > 0) begin m_rd = mm[m_head % 4][a]; m_rd_known = 1'b1; end
      else m_rd_known = 1'b0;
    end
    if (v) begin
      if (nfull < 2) begin
        mm[m_tail % 4][m_wcnt] = d;
        m_wcnt++;
        if (m_wcnt == TILE_WORDS) begin
          m_wcnt = 0; m_tail++; m_tcnt = (m_tcnt + 1) % 256;
        end
      end else m_ovf = 1'b1;
    end
    if (dn && nfull > 0) m_head++;
    @(posedge s_clk); #1;
    i_Calc_valid = 1'b0; i_rd_en = 1'b0; i_rd_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge s_clk);
    s_rst = 1'b1;
    #2;
    s_rst = 1'b0;
    model_reset();
    @(posedge s_clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (o_AttnRAM_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", o_AttnRAM_Ready); end
    n_chk++; if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", o_rd_valid); end
    n_chk++; if (o_tile_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_tile_cnt got %0d exp 0", o_tile_cnt); end
    n_chk++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", o_ovf); end
    n_chk++; if (o_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data got %0h exp 0", o_rd_data); end
  endtask

  task automatic test_single_tile();
    do_reset();
    for (int i = 0; i < TILE_WORDS - 1; i++) step(1'b1, DATA_W'(i), 1'b0, 0, 1'b0);
    n_chk++; if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL partial_rd_valid got %b exp 0", o_rd_valid); end
    step(1'b1, DATA_W'(TILE_WORDS - 1), 1'b0, 0, 1'b0);
    n_chk++; if (o_rd_valid !== 1'b1) begin n_fail++; $display("FAIL tile1_rd_valid got %b exp 1", o_rd_valid); end
    n_chk++; if (o_tile_cnt !== 8'd1) begin n_fail++; $display("FAIL tile1_cnt got %0d exp 1", o_tile_cnt); end
    n_chk++; if (o_AttnRAM_Ready !== 1'b1) begin n_fail++; $display("FAIL tile1_ready got %b exp 1", o_AttnRAM_Ready); end
    step(1'b0, '0, 1'b1, 5, 1'b0);
    n_chk++; if (o_rd_data !== DATA_W'(5)) begin n_fail++; $display("FAIL tile1_rd5 got %0d exp 5", o_rd_data); end
    step(1'b0, '0, 1'b0, 9, 1'b0);
    n_chk++; if (o_rd_data !== DATA_W'(5)) begin n_fail++; $display("FAIL rd_hold got %0d exp 5", o_rd_data); end
  endtask

  // Continues from test_single_tile: bank0 FULL, bank1 EMPTY.
  task automatic test_overflow();
    for (int i = 0; i < TILE_WORDS; i++) step(1'b1, DATA_W'($urandom), 1'b0, 0, 1'b0);
    n_chk++; if (o_AttnRAM_Ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready got %b exp 0", o_AttnRAM_Ready); end
    n_chk++; if (o_tile_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_cnt_pre got %0d exp 2", o_tile_cnt); end
    n_chk++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %b exp 0", o_ovf); end
    step(1'b1, DATA_W'($urandom), 1'b0, 0, 1'b0);
    n_chk++; if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", o_ovf); end
    n_chk++; if (o_tile_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_cnt got %0d exp 2", o_tile_cnt); end
    // Releasing tile 1 must expose tile 2 with its original data, ovf sticky.
    step(1'b0, '0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      int a = int'($urandom_range(TILE_WORDS - 1));
      step(1'b0, '0, 1'b1, a, 1'b0);
      n_chk++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL ovf_tile2_rd a=%0d got %0h exp %0h", a, o_rd_data, m_rd); end
    end
    n_chk++; if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", o_ovf); end
  endtask

  task automatic test_done_on_last();
    do_reset();
    for (int i = 0; i < 2 * TILE_WORDS - 1; i++) step(1'b1, DATA_W'($urandom), 1'b0, 0, 1'b0);
    step(1'b1, DATA_W'($urandom), 1'b0, 0, 1'b1);
    n_chk++; if (o_rd_valid !== 1'b1) begin n_fail++; $display("FAIL dl_rd_valid got %b exp 1", o_rd_valid); end
    n_chk++; if (o_AttnRAM_Ready !== 1'b1) begin n_fail++; $display("FAIL dl_ready got %b exp 1", o_AttnRAM_Ready); end
    n_chk++; if (o_tile_cnt !== 8'd2) begin n_fail++; $display("FAIL dl_cnt got %0d exp 2", o_tile_cnt); end
    for (int k = 0; k < 4; k++) begin
      int a = int'($urandom_range(TILE_WORDS - 1));
      step(1'b0, '0, 1'b1, a, 1'b0);
      n_chk++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL dl_tile2_rd a=%0d got %0h exp %0h", a, o_rd_data, m_rd); end
    end
  endtask

  task automatic test_done_ignored();
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, DATA_W'($urandom), 1'b0, 0, 1'b0);
    step(1'b0, '0, 1'b0, 0, 1'b1);
    n_chk++; if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL di_rd_valid got %b exp 0", o_rd_valid); end
    for (int i = 100; i < TILE_WORDS; i++) step(1'b1, DATA_W'($urandom), 1'b0, 0, 1'b0);
    n_chk++; if (o_rd_valid !== 1'b1) begin n_fail++; $display("FAIL di_full got %b exp 1", o_rd_valid); end
    step(1'b0, '0, 1'b1, 200, 1'b0);
    n_chk++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL di_rd got %0h exp %0h", o_rd_data, m_rd); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < TILE_WORDS; i++) step(1'b1, DATA_W'($urandom), 1'b0, 0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, DATA_W'($urandom), 1'b0, 0, 1'b0);
    step(1'b0, '0, 1'b1, 3, 1'b0);
    // Assert reset between edges and sample before the next edge.
    #2 s_rst = 1'b1;
    #1;
    n_chk++; if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL mr_rd_valid got %b exp 0", o_rd_valid); end
    n_chk++; if (o_AttnRAM_Ready !== 1'b1) begin n_fail++; $display("FAIL mr_ready got %b exp 1", o_AttnRAM_Ready); end
    n_chk++; if (o_tile_cnt !== 8'd0) begin n_fail++; $display("FAIL mr_cnt got %0d exp 0", o_tile_cnt); end
    n_chk++; if (o_rd_data !== '0) begin n_fail++; $display("FAIL mr_rd_data got %0h exp 0", o_rd_data); end
    @(negedge s_clk); s_rst = 1'b0;
    model_reset();
    @(posedge s_clk); #1;
    for (int i = 0; i < TILE_WORDS; i++) step(1'b1, DATA_W'($urandom), 1'b0, 0, 1'b0);
    n_chk++; if (o_tile_cnt !== 8'd1) begin n_fail++; $display("FAIL mr_cnt_after got %0d exp 1", o_tile_cnt); end
    for (int a = 0; a < TILE_WORDS; a += 51) begin
      step(1'b0, '0, 1'b1, a, 1'b0);
      n_chk++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL mr_rd a=%0d got %0h exp %0h", a, o_rd_data, m_rd); end
    end
  endtask

  // Random mix of writes, reads and releases against the tile-FIFO model.
  task automatic test_random_mix();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic v, re, dn;
      v  = ($urandom_range(99) < 85);
      re = ($urandom_range(1) == 1);
      dn = ($urandom_range(299) == 0);
      step(v, DATA_W'($urandom), re, int'($urandom_range(TILE_WORDS - 1)), dn);
      n_chk++; if (o_AttnRAM_Ready !== (m_tail - m_head < 2)) begin n_fail++; $display("FAIL rm_ready c=%0d got %b", c, o_AttnRAM_Ready); end
      n_chk++; if (o_rd_valid !== (m_tail - m_head > 0)) begin n_fail++; $display("FAIL rm_rd_valid c=%0d got %b", c, o_rd_valid); end
      n_chk++; if (o_tile_cnt !== 8'(m_tcnt)) begin n_fail++; $display("FAIL rm_cnt c=%0d got %0d exp %0d", c, o_tile_cnt, m_tcnt); end
      n_chk++; if (o_ovf !== m_ovf) begin n_fail++; $display("FAIL rm_ovf c=%0d got %b exp %b", c, o_ovf, m_ovf); end
      if (last_re && m_rd_known) begin
        n_chk++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL rm_rd c=%0d got %0h exp %0h", c, o_rd_data, m_rd); end
      end
    end
  endtask

  // 256 tiles streamed; the previous tile is read while the next is written.
  task automatic test_wrap();
    int bad = 0;
    do_reset();
    for (int t = 0; t < 256; t++) begin
      for (int i = 0; i < TILE_WORDS; i++) begin
        logic re = (t > 0);
        step(1'b1, DATA_W'($urandom), re, int'($urandom_range(TILE_WORDS - 1)),
             re && (i == TILE_WORDS - 1));
        if (re && m_rd_known) begin
          n_chk++;
          if (o_rd_data !== m_rd) begin
            n_fail++; bad++;
            if (bad < 20) $display("FAIL wrap_rd t=%0d i=%0d got %0h exp %0h", t, i, o_rd_data, m_rd);
          end
        end
      end
    end
    n_chk++; if (o_tile_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt got %0d exp 0", o_tile_cnt); end
    n_chk++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got %b exp 0", o_ovf); end
    n_chk++; if (o_rd_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_rd_valid got %b exp 1", o_rd_valid); end
  endtask

  initial begin
    model_reset();
    last_re = 1'b0;
    test_reset();
    test_single_tile();
    test_overflow();
    test_done_on_last();
    test_done_ignored();
    test_mid_reset();
    test_random_mix();
    test_wrap();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
